// File: rtl/time_ctrl_pkg.sv
// Shared types and field moduli for the time_set_ctrl timekeeping slice.
package time_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10,
        SET_SEC = 2'b11
    } state_t;

    localparam int SEC_MOD = 60;
    localparam int MIN_MOD = 60;

endpackage

// File: rtl/time_set_ctrl_wrap_counter.sv
// Modulo-N up-counter with a carry that flags the wrapping increment.
module wrap_counter #(
    parameter int N = 60,
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         carry
);

    logic at_max;

    assign at_max = (q == W'(N - 1));
    assign carry  = inc & at_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (inc)
            q <= at_max ? '0 : q + W'(1);
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Seconds/minutes/hours controller: 1 Hz prescaler, carry chain and set-mode FSM.
// Define ALARM_EN to add the alarm compare ports and the alarm_hit pulse.
//
// state   | meaning
// RUN     | clock running, prescaler ticks sec, carries ripple to min/hour
// SET_HR  | prescaler held, inc_btn bumps hour only
// SET_MIN | prescaler held, inc_btn bumps min only
// SET_SEC | prescaler held, inc_btn bumps sec only
module time_set_ctrl
    import time_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int HOUR_MOD = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       inc_btn,
`ifdef ALARM_EN
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    output logic       alarm_hit,
`endif
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic       sec_tick,
    output logic [1:0] edit_sel
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_ARM  = PW'(TICK_DIV - 2);

    state_t        state;
    logic [PW-1:0] presc;
    logic          inc_ok;
    logic          sec_inc, min_inc, hour_inc;
    logic          sec_carry, min_carry, day_rollover;

    // mode_btn wins over a simultaneous inc_btn
    assign inc_ok   = inc_btn & ~mode_btn;
    assign edit_sel = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            presc    <= '0;
            sec_tick <= 1'b0;
        end else begin
            presc    <= '0;
            sec_tick <= 1'b0;
            case (state)
                RUN: begin
                    if (mode_btn) begin
                        state <= SET_HR;
                    end else begin
                        presc    <= (presc == PRE_LAST) ? '0 : presc + PW'(1);
                        // register the tick so it is high while presc sits at its last count
                        sec_tick <= (presc == PRE_ARM);
                    end
                end
                SET_HR:  if (mode_btn) state <= SET_MIN;
                SET_MIN: if (mode_btn) state <= SET_SEC;
                SET_SEC: if (mode_btn) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    always_comb begin
        sec_inc  = 1'b0;
        min_inc  = 1'b0;
        hour_inc = 1'b0;
        case (state)
            RUN: begin
                sec_inc  = sec_tick;
                min_inc  = sec_carry;
                hour_inc = min_carry;
            end
            SET_HR:  hour_inc = inc_ok;
            SET_MIN: min_inc  = inc_ok;
            SET_SEC: sec_inc  = inc_ok;
            default: ;
        endcase
    end

    wrap_counter #(.N(SEC_MOD), .W(6)) u_sec (
        .clk(clk), .rst(rst), .inc(sec_inc), .q(sec), .carry(sec_carry)
    );

    wrap_counter #(.N(MIN_MOD), .W(6)) u_min (
        .clk(clk), .rst(rst), .inc(min_inc), .q(min), .carry(min_carry)
    );

    wrap_counter #(.N(HOUR_MOD), .W(5)) u_hour (
        .clk(clk), .rst(rst), .inc(hour_inc), .q(hour), .carry(day_rollover)
    );

`ifdef ALARM_EN
    logic [5:0] min_after;
    logic [4:0] hour_after;

    // predict the post-tick fields so the pulse lines up with the displayed match
    assign min_after  = min_carry ? 6'd0 : min + 6'd1;
    assign hour_after = day_rollover ? 5'd0 : (min_carry ? hour + 5'd1 : hour);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            alarm_hit <= 1'b0;
        else
            alarm_hit <= sec_tick & sec_carry &
                         (min_after == alarm_min) & (hour_after == alarm_hour);
    end
`else
    logic unused_day_rollover;
    assign unused_day_rollover = day_rollover;
`endif

endmodule
